// File: rtl/servant_uart_pkg.sv
// Shared types and constants for the servant UART receiver.
package servant_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_t;

  localparam int DATA_BITS      = 8;
  localparam int BIT_CYCLES_DEF = 278;

endpackage

// File: rtl/servant_sync.sv
// N-flop synchronizer for asynchronous single-bit inputs; resets to a preset value.
module servant_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff <= {STAGES{RESET_VAL}};
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/servant_uart_rx.sv
// 8N1 UART receiver with valid/ready output and framing/overrun error pulses.
//   state     | meaning
//   IDLE      | line idle, waiting for a falling edge
//   START     | timing to mid start bit to reject glitches
//   DATA      | sampling 8 data bits at mid-bit, LSB first
//   STOP      | sampling the stop bit, delivering or dropping the byte
//   WAIT_IDLE | after a framing error, wait for the line to return high
module servant_uart_rx
  import servant_uart_pkg::*;
#(
  parameter int BIT_CYCLES  = BIT_CYCLES_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 wb_clk,
  input  logic                 wb_rst_n,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_frame_err,
  output logic                 o_overrun
);

  localparam int             CW      = $clog2(BIT_CYCLES);
  localparam logic [CW-1:0]  HALF_M1 = CW'(BIT_CYCLES / 2 - 1);
  localparam logic [CW-1:0]  FULL_M1 = CW'(BIT_CYCLES - 1);
  localparam logic [2:0]     LAST_BIT = 3'(DATA_BITS - 1);

  rx_state_t            state;
  logic [CW-1:0]        cnt;
  logic [2:0]           bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 rx_s;

  servant_sync #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk   (wb_clk),
    .rst_n (wb_rst_n),
    .d     (i_rx),
    .q     (rx_s)
  );

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      o_data      <= '0;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
      if (o_valid && i_ready) o_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            cnt   <= '0;
          end
        end

        START: begin
          if (cnt == HALF_M1) begin
            if (!rx_s) begin
              state   <= DATA;
              cnt     <= '0;
              bit_cnt <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        DATA: begin
          if (cnt == FULL_M1) begin
            cnt     <= '0;
            shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == LAST_BIT) state <= STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        STOP: begin
          if (cnt == FULL_M1) begin
            cnt <= '0;
            if (rx_s) begin
              // An accept in this same cycle frees the slot for the new byte.
              if (!o_valid || i_ready) begin
                o_data  <= shreg;
                o_valid <= 1'b1;
              end else begin
                o_overrun <= 1'b1;
              end
              state <= IDLE;
            end else begin
              o_frame_err <= 1'b1;
              state       <= WAIT_IDLE;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        WAIT_IDLE: begin
          if (rx_s) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/servant_uart_rx.md
Name: servant_uart_rx

Overview:
- Synthesizable 8N1 UART receiver that decodes the serial bit stream the servant SoC drives on its `q` pin.
- Used in two places:
  - In the simulation harness, as a self-checking console decoder.
  - On FPGA boards, in a loopback/monitor build.
- Delivers each received byte on a valid/ready handshake and flags framing and overrun errors.

Parameters:
- BIT_CYCLES, 278, wb_clk cycles per bit period (32 MHz / 115200 baud); must be >= 4.
- SYNC_STAGES, 2, number of flops in the input synchronizer (>= 2).

Ports:
- wb_clk  in  1  system clock; all logic on rising edge.
- wb_rst_n  in  1  asynchronous active-low reset.
- i_rx  in  1  serial line; idle high, asynchronous to wb_clk.
- o_data  out  8  received byte, LSB first on the wire; stable while o_valid=1.
- o_valid  out  1  byte available; held until accepted.
- i_ready  in  1  consumer accepts the byte when o_valid & i_ready.
- o_frame_err  out  1  one-cycle pulse: stop bit sampled low.
- o_overrun  out  1  one-cycle pulse: byte completed while previous byte still unaccepted.

Behaviour:
- Reset values:
  - o_data=0, o_valid=0, o_frame_err=0, o_overrun=0.
  - Synchronizer flops preset to 1, so the line reads idle.
  - State=IDLE, bit counter=0, cycle counter=0.
- rx_s is the synchronized i_rx, delayed by SYNC_STAGES cycles.
- Cycle counter width is clog2(BIT_CYCLES); it counts 0..BIT_CYCLES-1 and wraps to 0.
- Bit counter is 3 bits.
- IDLE: on rx_s==0, go to START and load the cycle counter with 0.
- START: when cycle counter reaches BIT_CYCLES/2-1 (mid start bit), sample rx_s.
  - rx_s==0: go to DATA, cycle counter=0, bit counter=0.
  - rx_s==1: false start (glitch); return to IDLE with no output.
- DATA: when cycle counter reaches BIT_CYCLES-1 (mid data bit), shift rx_s into bit 7 of the shift register (right shift) and increment the bit counter.
  - After the 8th sample (bit counter wraps 7->0), go to STOP.
- STOP: at the next mid-bit point, sample rx_s.
  - rx_s==1: byte complete.
    - If o_valid==0, or o_valid & i_ready in that same cycle: o_data<=shift register, o_valid<=1.
    - Otherwise: o_overrun pulses 1 cycle; the old byte is kept and the new byte is dropped.
    - Go to IDLE.
  - rx_s==0: o_frame_err pulses 1 cycle, byte discarded, go to WAIT_IDLE.
- WAIT_IDLE: stay until rx_s==1, then go to IDLE. This prevents a break condition from retriggering frames.
- Handshake:
  - o_valid clears the cycle after o_valid & i_ready.
  - A simultaneous accept and new byte completion loads the new byte with o_valid still 1 and raises no overrun.
  - i_ready while o_valid==0 has no effect.
- Latency:
  - A byte appears a fixed time after the falling edge of its start bit: SYNC_STAGES + BIT_CYCLES/2 + 9*BIT_CYCLES cycles, ±1.
  - The next start bit is detected as early as the cycle after STOP; back-to-back frames with a 1-bit stop are supported.
- Reset asserted mid-frame:
  - All state returns to reset values immediately; any pending byte is lost.
  - After release, the receiver resynchronizes on the next falling edge seen in IDLE.
  - If reset is released while the line is low, a spurious START may occur. It is rejected as a false start, or produces a frame error, never a hang.

Decomposition:
- Package servant_uart_pkg holds:
  - State enum: IDLE, START, DATA, STOP, WAIT_IDLE.
  - Constants: DATA_BITS=8, default BIT_CYCLES.
- Sub-module servant_sync: parameterized N-flop synchronizer with async active-low reset to a preset value. It is reusable by other servant peripherals.

Test Plan:
- Send 0x55 then 0xA3 back-to-back at BIT_CYCLES=16, i_ready tied 1 -> o_valid pulses twice with o_data 0x55 then 0xA3; no error pulses.
- 0.25-bit low glitch on idle line -> START rejects it; no o_valid and no errors; state returns to IDLE.
- Send 0x3C with the stop bit forced low, then release the line high -> one o_frame_err pulse, no o_valid, next frame 0x81 is received correctly.
- i_ready=0, send 0x11 then 0x22 -> o_valid stays 1 with o_data=0x11 and o_overrun pulses once; after i_ready=1, o_valid drops and o_data stays 0x11.
- Assert wb_rst_n low during bit 4 of 0xF0, release, then send 0x0F -> outputs go to 0 immediately; only 0x0F is delivered.
- Stress: 256 random bytes, ±2% baud skew, random i_ready backpressure -> every delivered byte matches the sent stream; drops coincide exactly with o_overrun pulses.
